// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the width of the shared hold/stage/watchdog counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    REL  = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned hold_cyc,
                                            input int unsigned stage_dly,
                                            input int unsigned wdt_cyc);
    int unsigned m;
    m = hold_cyc;
    if (stage_dly > m) m = stage_dly;
    if (wdt_cyc > m)   m = wdt_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// Two-flop reset synchroniser: asserts asynchronously with rst_asyn,
// deasserts on the second clk edge after rst_asyn rises.
module rst_sync_2ff (
  input  logic clk,
  input  logic rst_asyn,
  output logic rst_s
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = 1'b1;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_asyn) begin
    if (!rst_asyn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign rst_s = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets, then releases them one by one in
// bit order; optional watchdog built when RST_SEQ_WDT_EN is defined.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_DOM     = 3,
  parameter int unsigned HOLD_CYC  = 16,
  parameter int unsigned STAGE_DLY = 4,
  parameter int unsigned WDT_CYC   = 1024
) (
  input  logic             clk,
  input  logic             rst_asyn,
  input  logic             sw_rst_req,
  input  logic             wdt_kick,
  output logic [N_DOM-1:0] rst_n_out,
  output logic             busy,
  output logic             done,
  output logic             wdt_evt
);

  localparam int unsigned CW = cnt_width(HOLD_CYC, STAGE_DLY, WDT_CYC);
  localparam int unsigned SW = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DLY - 1);
`ifdef RST_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST   = CW'(WDT_CYC - 1);
`else
  logic wdt_kick_unused;
  assign wdt_kick_unused = wdt_kick;
`endif

  logic             rst_s;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [N_DOM-1:0] rst_n_q, rst_n_d;
  logic             done_q, done_d;
  logic             wdt_evt_q, wdt_evt_d;

  rst_sync_2ff u_rst_sync (
    .clk      (clk),
    .rst_asyn (rst_asyn),
    .rst_s    (rst_s)
  );

  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_n_q   <= '0;
      done_q    <= 1'b0;
      wdt_evt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      wdt_evt_q <= wdt_evt_d;
    end
  end

  // One counter serves the hold, the stage gaps and (in RUN) the watchdog.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_n_d   = rst_n_q;
    done_d    = 1'b0;
    wdt_evt_d = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          rst_n_d[0] = 1'b1;
          cnt_d      = '0;
          stage_d    = SW'(1);
          state_d    = (N_DOM == 1) ? RUN : REL;
          done_d     = (N_DOM == 1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        if (sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_n_d = '0;
        end else if (cnt_q == STAGE_LAST) begin
          for (int unsigned i = 1; i < N_DOM; i++) begin
            if (stage_q == SW'(i)) rst_n_d[i] = 1'b1;
          end
          cnt_d = '0;
          if (stage_q == SW'(N_DOM - 1)) begin
            state_d = RUN;
            done_d  = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (sw_rst_req) begin
          state_d = HOLD;
          cnt_d   = '0;
          rst_n_d = '0;
        end
`ifdef RST_SEQ_WDT_EN
        else if (wdt_kick) begin
          cnt_d = '0;
        end else if (cnt_q == WDT_LAST) begin
          wdt_evt_d = 1'b1;
          state_d   = HOLD;
          cnt_d     = '0;
          rst_n_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        rst_n_d = '0;
      end
    endcase
  end

  always_comb begin
    rst_n_out = rst_n_q;
    busy      = ~(&rst_n_q);
    done      = done_q;
    wdt_evt   = wdt_evt_q;
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: stimulus queues expected output changes
// with their edge numbers, a negedge monitor compares every observed change.
module tb_rst_seq_ctrl;

  localparam int unsigned N_DOM     = 3;
  localparam int unsigned HOLD_CYC  = 16;
  localparam int unsigned STAGE_DLY = 4;
  localparam int unsigned WDT_CYC   = 32;

  logic             clk = 1'b0;
  logic             rst_asyn;
  logic             sw_rst_req;
  logic             wdt_kick;
  logic [N_DOM-1:0] rst_n_out;
  logic             busy;
  logic             done;
  logic             wdt_evt;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] imm_act_q[$];
  logic [3:0] imm_exp_q[$];
  int         edge_cnt  = 0;
  int         checks    = 0;
  int         errors    = 0;
  bit         stim_done = 1'b0;

  rst_seq_ctrl #(
    .N_DOM     (N_DOM),
    .HOLD_CYC  (HOLD_CYC),
    .STAGE_DLY (STAGE_DLY),
    .WDT_CYC   (WDT_CYC)
  ) dut (
    .clk        (clk),
    .rst_asyn   (rst_asyn),
    .sw_rst_req (sw_rst_req),
    .wdt_kick   (wdt_kick),
    .rst_n_out  (rst_n_out),
    .busy       (busy),
    .done       (done),
    .wdt_evt    (wdt_evt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 time unit after edge n; anything driven then is sampled at n+1.
  task automatic wait_edge(input int n);
    while (edge_cnt < n) tick();
  endtask

  task automatic expect_ev(input int cyc, input logic [2:0] rn,
                           input logic b, input logic d, input logic w);
    exp_t e;
    e.cyc = cyc;
    e.v   = {rn, b, d, w};
    exp_q.push_back(e);
  endtask

  task automatic expect_seq(input int e0);
    expect_ev(e0 + 16, 3'b001, 1'b1, 1'b0, 1'b0);
    expect_ev(e0 + 20, 3'b011, 1'b1, 1'b0, 1'b0);
    expect_ev(e0 + 24, 3'b111, 1'b0, 1'b1, 1'b0);
    expect_ev(e0 + 25, 3'b111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sw_pulse_at(input int s);
    wait_edge(s - 1);
    sw_rst_req = 1'b1;
    wait_edge(s);
    sw_rst_req = 1'b0;
  endtask

  task automatic kick_at(input int s);
    wait_edge(s - 1);
    wdt_kick = 1'b1;
    wait_edge(s);
    wdt_kick = 1'b0;
  endtask

  initial begin
    rst_asyn   = 1'b0;
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;

    // Power-on: rst_asyn rises after edge 5, rst_s high at edge 7 = E0.
    expect_ev(1, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(7);
    wait_edge(5);
    rst_asyn = 1'b1;

    // Software request from RUN.
    expect_ev(41, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(41);
    sw_pulse_at(41);

    // Request in REL while 011: full hold restarts.
    expect_ev(80, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_ev(96, 3'b001, 1'b1, 1'b0, 1'b0);
    expect_ev(100, 3'b011, 1'b1, 1'b0, 1'b0);
    expect_ev(102, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(102);
    sw_pulse_at(80);
    sw_pulse_at(102);

    // Request coinciding with the final release: no release, no done.
    expect_ev(140, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_ev(156, 3'b001, 1'b1, 1'b0, 1'b0);
    expect_ev(160, 3'b011, 1'b1, 1'b0, 1'b0);
    expect_ev(164, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(164);
    sw_pulse_at(140);
    sw_pulse_at(164);

    // Short asynchronous rst_asyn pulse mid-REL.
    expect_ev(200, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_ev(216, 3'b001, 1'b1, 1'b0, 1'b0);
    expect_ev(220, 3'b011, 1'b1, 1'b0, 1'b0);
    expect_ev(221, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(223);
    sw_pulse_at(200);
    wait_edge(221);
    #1 rst_asyn = 1'b0;
    #1;
    imm_act_q.push_back({rst_n_out, busy});
    imm_exp_q.push_back(4'b0001);
    #1 rst_asyn = 1'b1;

    // Request held high through the whole hold: timing unchanged.
    expect_ev(260, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(260);
    wait_edge(259);
    sw_rst_req = 1'b1;
    wait_edge(276);
    sw_rst_req = 1'b0;

`ifdef RST_SEQ_WDT_EN
    // RUN from 284 unkicked fires at 316; kicks 350..410 then silence to 442;
    // kick exactly on the timeout edge 498 defers the fire to 530.
    expect_ev(316, 3'b000, 1'b1, 1'b0, 1'b1);
    expect_ev(317, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(316);
    expect_ev(442, 3'b000, 1'b1, 1'b0, 1'b1);
    expect_ev(443, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(442);
    expect_ev(530, 3'b000, 1'b1, 1'b0, 1'b1);
    expect_ev(531, 3'b000, 1'b1, 1'b0, 1'b0);
    expect_seq(530);
`endif
    kick_at(350);
    kick_at(370);
    kick_at(390);
    kick_at(410);
    kick_at(498);
    wait_edge(560);
    stim_done = 1'b1;
  end

  initial begin
    logic [5:0] prev;
    logic [5:0] cur;
    logic [3:0] a;
    logic [3:0] e4;
    exp_t       e;
    prev = 'x;
    forever begin
      @(negedge clk);
      while (imm_exp_q.size() > 0) begin
        a  = imm_act_q.pop_front();
        e4 = imm_exp_q.pop_front();
        checks++;
        if (a !== e4) begin
          errors++;
          $display("FAIL async_abort: rst_n_out/busy=%b, required %b", a, e4);
        end
      end
      cur = {rst_n_out, busy, done, wdt_evt};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: edge %0d {rst_n,busy,done,wdt}=%b, required %b",
                   edge_cnt, cur, prev);
        end else begin
          e = exp_q.pop_front();
          if (e.v !== cur || e.cyc != edge_cnt) begin
            errors++;
            $display("FAIL output_event: got %b at edge %0d, required %b at edge %0d",
                     cur, edge_cnt, e.v, e.cyc);
          end
        end
        prev = cur;
      end
      if (stim_done) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL missing_events: %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, required stim_done");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/rst_seq_ctrl.md
# rst_seq_ctrl

Reset sequencer that originates and distributes resets. It synchronises the board-level asynchronous reset, holds all downstream domain resets asserted for a minimum time, then releases them one domain at a time in a fixed order. It also accepts synchronous software reset requests and re-runs the sequence. It sits at the top of the clock/reset tree and feeds the per-domain reset synchronisers.

## Interface

**Parameters**
- `N_DOM`, default 3: number of downstream reset outputs; must be ≥1.
- `HOLD_CYC`, default 16: cycles all outputs stay asserted before the first release; must be ≥1.
- `STAGE_DLY`, default 4: cycles between consecutive domain releases; must be ≥1.
- `WDT_CYC`, default 1024: watchdog timeout in cycles; used only with `RST_SEQ_WDT_EN`.

**Ports**
- `clk`, input, 1: clock.
- `rst_asyn`, input, 1: reset, asynchronous, active-low.
- `sw_rst_req`, input, 1: synchronous software reset request, level-sampled each cycle.
- `wdt_kick`, input, 1: watchdog service strobe.
- `rst_n_out`, output, N_DOM: active-low domain resets; bit 0 is released first.
- `busy`, output, 1: high while any `rst_n_out` bit is asserted.
- `done`, output, 1: one-cycle pulse when the last domain is released.
- `wdt_evt`, output, 1: one-cycle pulse when the watchdog fires.

## Operation

- Internal reset `rst_s`:
  - Produced from `rst_asyn` by a 2-flop synchroniser.
  - Assertion is asynchronous.
  - Deassertion is seen 2 clock edges after `rst_asyn` rises.
- FSM states are HOLD, REL and RUN.
- While `rst_s` is low:
  - state = HOLD and counter = 0.
  - `rst_n_out` = 0 (all bits), `busy` = 1, `done` = 0, `wdt_evt` = 0.
  - Outputs are forced asynchronously.
- HOLD:
  - Counter increments every cycle.
  - When counter = HOLD_CYC-1, the next edge sets `rst_n_out[0]` = 1, clears the counter and moves to REL.
  - If N_DOM = 1, that edge goes to RUN instead and pulses `done`.
- REL:
  - Counter increments every cycle. Stage index k starts at 1.
  - When counter = STAGE_DLY-1, the next edge sets `rst_n_out[k]` = 1, then increments k and clears the counter.
  - Releasing bit N_DOM-1 moves to RUN and pulses `done` on that same edge.
- RUN:
  - `busy` = 0.
  - `sw_rst_req` = 1 → next edge: `rst_n_out` = 0, `busy` = 1, state = HOLD, counter = 0.
- `sw_rst_req` during HOLD is ignored; the hold is not extended.
- `sw_rst_req` during REL:
  - Restarts the sequence: next edge `rst_n_out` = 0, state HOLD, counter 0.
  - If it coincides with the final release, the request wins: no `done` pulse and no release.
- `rst_asyn` falling at any point aborts immediately to the reset values above.
- Released bits never re-assert except via `sw_rst_req`, the watchdog, or `rst_asyn`.
- Counter width is $clog2(max(HOLD_CYC, STAGE_DLY, WDT_CYC)+1). The counter never wraps; it is compared and cleared.

## Timing

- Let edge E0 be the first edge on which `rst_s` is high.
- `rst_n_out[0]` rises at E0+HOLD_CYC.
- `rst_n_out[k]` rises at E0+HOLD_CYC+k·STAGE_DLY.
- `done` is high for exactly the cycle following the rise of `rst_n_out[N_DOM-1]`. `busy` falls on the same edge.
- From a RUN `sw_rst_req`, sample edge S is the new E0: outputs assert at S and release at S+HOLD_CYC+k·STAGE_DLY.
- Total sequence length is HOLD_CYC+(N_DOM-1)·STAGE_DLY edges.

## Configuration

Macro: `RST_SEQ_WDT_EN`.

- **Defined:**
  - A watchdog counter runs only in RUN and clears on `wdt_kick` = 1 or on leaving RUN.
  - At count WDT_CYC-1 without a kick, the next edge pulses `wdt_evt` and starts a reset exactly as `sw_rst_req` does.
  - A kick on the timeout cycle prevents the fire.
- **Undefined:**
  - No watchdog logic is built.
  - `wdt_kick` is ignored and `wdt_evt` is tied to 0.
  - Ports remain for a stable interface.

## Structure

- Package `rst_seq_pkg` holds:
  - The state encoding localparams (HOLD = 2'd0, REL = 2'd1, RUN = 2'd2).
  - The counter width function.
- Sub-module `rst_sync_2ff` generates `rst_s` (asynchronous assert, 2-flop synchronous deassert). It is instantiated once.
- The FSM, counter, stage index and watchdog live in `rst_seq_ctrl`.

## Test plan

All scenarios use N_DOM = 3, HOLD_CYC = 16, STAGE_DLY = 4, WDT_CYC = 32.

1. Power-on: `rst_asyn` low 5 cycles, then high → `rst_n_out` = 000 until E0+16 (E0 = 2 edges after the rise). Expect 001 at E0+16, 011 at E0+20, 111 at E0+24, `done` high one cycle at E0+24, `busy` 0 thereafter.
2. RUN with `sw_rst_req` = 1 for one cycle → `rst_n_out` = 000 on the next edge, then 001/011/111 at +16/+20/+24, one `done` pulse.
3. `sw_rst_req` during REL when `rst_n_out` = 011 → 000 on the next edge, full 16-cycle hold restarts. A request coinciding with the 111 edge gives 000 and no `done`.
4. `rst_asyn` pulsed low mid-REL, asynchronous to `clk` → `rst_n_out` = 000 and `busy` = 1 immediately without a clock edge. Sequence restarts 2 edges after release.
5. `sw_rst_req` held high through HOLD → release times are unchanged from scenario 2; the hold is not extended.
6. With `RST_SEQ_WDT_EN`, no kicks in RUN → `wdt_evt` pulses at RUN+32, `rst_n_out` = 000, sequence reruns. Kicking every 20 cycles keeps `wdt_evt` = 0. Without the macro, `wdt_evt` stays 0.
